day10_min_presses_solver: RTL and testbench
===========================================

# day10_min_presses_solver

Exhaustive solver for one Day 10 machine: finds the minimum number of button presses whose combined XOR toggle pattern equals the target light arrangement. Sits directly downstream of the `day10_input_if` producer, the parser that fills in lights, buttons and target. It takes the `consumer` modport plus a valid/ready handshake, enumerates every button subset at one subset per cycle, and returns the best press count and button mask to the accumulator stage.

## Interface
- `MAX_NUM_LIGHTS`, default 10: light vector width; must match the interface instance.
- `MAX_NUM_BUTTONS`, default 13: button array depth; must match the interface instance.
- `MAX_NUM_BUTTONS_W`, default `MAX_NUM_BUTTONS<=1 ? 1 : $clog2(MAX_NUM_BUTTONS+1)`: count width.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  machine on `machine` is valid.
- `in_ready`  out  1  solver idle and accepting.
- `machine`  `day10_input_if.consumer`  machine description: `num_lights`, `num_buttons`, `buttons`, `target_lights_arrangement`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `found`  out  1  at least one subset reaches the target.
- `min_presses`  out  `MAX_NUM_BUTTONS_W`  minimum press count; 0 when `found`=0.
- `best_mask`  out  `MAX_NUM_BUTTONS`  winning subset, bit i = button i; 0 when `found`=0.

## Operation
- FSM with three states.
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, capture all inputs, clear the best registers and go to SEARCH.
  - SEARCH: evaluate subset `k` (counter k = 0 .. 2^N−1), then go to DONE after the last subset.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Capture rules:
  - N = min(`num_buttons`, `MAX_NUM_BUTTONS`) and L = min(`num_lights`, `MAX_NUM_LIGHTS`).
  - Buttons at index ≥ N are zeroed on capture.
  - Light bits ≥ L are masked out of both the buttons and the target on capture.
- Per-subset evaluation:
  - pattern = XOR of captured buttons selected by `k`; computed combinationally from the counter.
  - popcount(k) is `MAX_NUM_BUTTONS_W` bits.
  - Match means pattern == masked target.
  - On a match with (!found_r || popcount < best_count), update best_count, best_mask and found_r.
  - The comparison is strict, so ties keep the lowest `k`.
- The subset counter is `MAX_NUM_BUTTONS`+1 bits wide and never wraps. The termination test is k == 2^N−1.
- When N = 0, exactly one subset (k = 0, the empty set) is evaluated.
- `found`, `min_presses` and `best_mask` are registered and held stable while `out_valid`=1. They change only when the next machine is accepted.
- Inputs on `machine` are ignored outside the capture cycle and may change freely afterwards.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `found`=0, `min_presses`=0, `best_mask`=0, counter 0.
- Let T be the accept edge. Subset k is evaluated in cycle T+1+k.
- `out_valid` rises in cycle T+2^N+1. Latency is 2^N+1 cycles, or 2 cycles when N=0.
- `in_ready`=0 from T+1 until the cycle after the `out_ready` handshake. There is no accept in the same cycle as the result handshake.
- Backpressure: `out_valid` stays high and the outputs stay frozen for any number of cycles with `out_ready`=0.
- `out_ready` asserted while not in DONE has no effect.
- `rst_n`=0 in any state, including mid-SEARCH: at the next edge, return to the reset values above. No partial result is emitted.

## Configuration
- `DAY10_EARLY_EXIT_EN` defined: SEARCH ends early once the result is provably optimal. The exit condition is found_r && best_count == (target==0 ? 0 : 1). DONE is entered the cycle after the proving subset is evaluated.
  - Zero target: `out_valid` rises at T+2.
  - Target equal to button 0: `out_valid` rises at T+3.
- Not defined: the full 2^N enumeration always runs. Results are identical either way; only latency differs.

## Test plan
- Worked example: L=4, N=6, buttons {1000,1010,0100,1100,0101,0011}, target 0110.
  - Required: `found`=1, `min_presses`=2, `best_mask`=6'b001010.
  - `out_valid` at T+65 with or without the macro (the answer is 2, so early exit never triggers).
- Zero target: N=5, target 0000.
  - Required: `found`=1, `min_presses`=0, `best_mask`=0.
  - `out_valid` at T+33 without the macro, T+2 with it.
- Unreachable target: N=1, button 0001, target 0010.
  - Required: `found`=0, `min_presses`=0, `best_mask`=0 at T+3.
- Masking: L=2, N=2, buttons {1101, 0110}, target 0001 (upper bits ignored).
  - Required: `min_presses`=1, `best_mask`=2'b01.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - Outputs stay stable and `in_ready`=0 throughout.
  - After the handshake, `in_ready`=1 on the next cycle and a second machine is accepted correctly.
- Reset mid-search: assert `rst_n`=0 at T+20 of the worked example.
  - Next cycle shows the reset values and no `out_valid` pulse.
  - A re-issued machine then gives the correct result.

Source files
------------

// File: rtl/day10_input_if.sv
// Machine description bus between the Day 10 parser (producer) and its consumers.
// Light/button counts are sized to hold 0..MAX inclusive.
interface day10_input_if #(
  parameter int unsigned MAX_NUM_LIGHTS  = 10,
  parameter int unsigned MAX_NUM_BUTTONS = 13
);
  localparam int unsigned NUM_LIGHTS_W  = $clog2(MAX_NUM_LIGHTS + 1);
  localparam int unsigned NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1);

  logic [NUM_LIGHTS_W-1:0]   num_lights;
  logic [NUM_BUTTONS_W-1:0]  num_buttons;
  logic [MAX_NUM_LIGHTS-1:0] buttons [MAX_NUM_BUTTONS];
  logic [MAX_NUM_LIGHTS-1:0] target_lights_arrangement;

  modport producer (output num_lights, num_buttons, buttons, target_lights_arrangement);
  modport consumer (input  num_lights, num_buttons, buttons, target_lights_arrangement);
  modport master   (output num_lights, num_buttons, buttons, target_lights_arrangement);
  modport slave    (input  num_lights, num_buttons, buttons, target_lights_arrangement);
endinterface

// File: rtl/day10_min_presses_solver.sv
// Exhaustive minimum-press solver: one button subset per cycle, strict-less update keeps lowest k.
// Optional macro DAY10_EARLY_EXIT_EN stops the search once the best result is provably optimal.
module day10_min_presses_solver #(
  parameter int unsigned MAX_NUM_LIGHTS    = 10,
  parameter int unsigned MAX_NUM_BUTTONS   = 13,
  parameter int unsigned MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  day10_input_if.consumer              machine,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         found,
  output logic [MAX_NUM_BUTTONS_W-1:0] min_presses,
  output logic [MAX_NUM_BUTTONS-1:0]   best_mask
);
  localparam int unsigned NL_W = $clog2(MAX_NUM_LIGHTS + 1);
  localparam int unsigned NB_W = $clog2(MAX_NUM_BUTTONS + 1);
  localparam int unsigned K_W  = MAX_NUM_BUTTONS + 1;
  localparam int unsigned CW   = MAX_NUM_BUTTONS_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]                state_r, state_nxt;
  logic [K_W-1:0]            k_r, last_k_r;
  logic [MAX_NUM_LIGHTS-1:0] btn_r [MAX_NUM_BUTTONS];
  logic [MAX_NUM_LIGHTS-1:0] target_r;

  logic [NB_W-1:0]           n_c;
  logic [NL_W-1:0]           l_c;
  logic [MAX_NUM_LIGHTS-1:0] light_mask_c;
  logic [MAX_NUM_LIGHTS-1:0] btn_cap_c [MAX_NUM_BUTTONS];
  logic [K_W-1:0]            last_k_c;
  logic [MAX_NUM_LIGHTS-1:0] pattern_c;
  logic [CW-1:0]             pop_c;
  logic                      better_c;
  logic                      proven_c;
  logic                      accept_c;

  // Clamp counts and mask the incoming machine so only real lights/buttons survive capture
  always_comb begin
    n_c = (machine.num_buttons > NB_W'(MAX_NUM_BUTTONS)) ? NB_W'(MAX_NUM_BUTTONS) : machine.num_buttons;
    l_c = (machine.num_lights > NL_W'(MAX_NUM_LIGHTS)) ? NL_W'(MAX_NUM_LIGHTS) : machine.num_lights;
    light_mask_c = '0;
    for (int j = 0; j < int'(MAX_NUM_LIGHTS); j++) begin
      light_mask_c[j] = (NL_W'(j) < l_c);
    end
    for (int i = 0; i < int'(MAX_NUM_BUTTONS); i++) begin
      btn_cap_c[i] = (NB_W'(i) < n_c) ? (machine.buttons[i] & light_mask_c) : '0;
    end
    last_k_c = (K_W'(1) << n_c) - K_W'(1);
  end

  // XOR pattern and press count of the subset currently selected by k
  always_comb begin
    pattern_c = '0;
    pop_c     = '0;
    for (int i = 0; i < int'(MAX_NUM_BUTTONS); i++) begin
      if (k_r[i]) begin
        pattern_c = pattern_c ^ btn_r[i];
        pop_c     = pop_c + CW'(1);
      end
    end
    better_c = (pattern_c == target_r) && (!found || (pop_c < min_presses));
  end

`ifdef DAY10_EARLY_EXIT_EN
  // Zero presses is optimal for a zero target, one press for any other target
  always_comb begin
    logic          found_eff;
    logic [CW-1:0] cnt_eff;
    found_eff = found | better_c;
    cnt_eff   = better_c ? pop_c : min_presses;
    proven_c  = found_eff && (cnt_eff == ((target_r == '0) ? CW'(0) : CW'(1)));
  end
`else
  assign proven_c = 1'b0;
`endif

  assign accept_c = (state_r == S_IDLE) && in_valid;

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE:   if (in_valid) state_nxt = S_SEARCH;
      S_SEARCH: if ((k_r == last_k_r) || proven_c) state_nxt = S_DONE;
      S_DONE:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
    end
  end

  // Capture on accept; track the best subset while searching
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_r         <= '0;
      last_k_r    <= '0;
      btn_r       <= '{default: '0};
      target_r    <= '0;
      found       <= 1'b0;
      min_presses <= '0;
      best_mask   <= '0;
    end else if (accept_c) begin
      k_r         <= '0;
      last_k_r    <= last_k_c;
      btn_r       <= btn_cap_c;
      target_r    <= machine.target_lights_arrangement & light_mask_c;
      found       <= 1'b0;
      min_presses <= '0;
      best_mask   <= '0;
    end else if (state_r == S_SEARCH) begin
      if (better_c) begin
        found       <= 1'b1;
        min_presses <= pop_c;
        best_mask   <= k_r[MAX_NUM_BUTTONS-1:0];
      end
      if (state_nxt == S_SEARCH) k_r <= k_r + K_W'(1);
    end
  end
endmodule

// File: tb/tb_day10_min_presses_solver.sv
// Directed table-driven bench for day10_min_presses_solver plus backpressure and mid-search reset sequences.
module tb_day10_min_presses_solver;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        found;
  logic [3:0]  min_presses;
  logic [12:0] best_mask;

  int checks = 0;
  int errors = 0;

  day10_input_if #(.MAX_NUM_LIGHTS(10), .MAX_NUM_BUTTONS(13)) mif ();

  day10_min_presses_solver #(.MAX_NUM_LIGHTS(10), .MAX_NUM_BUTTONS(13)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .machine(mif),
    .out_valid(out_valid), .out_ready(out_ready), .found(found),
    .min_presses(min_presses), .best_mask(best_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       nl;
    logic [3:0]       nb;
    logic [12:0][9:0] btn;
    logic [9:0]       tgt;
    logic             ef;
    logic [3:0]       emin;
    logic [12:0]      emask;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  function automatic vec_t mk(int nl, int nb, logic [9:0] b0, logic [9:0] b1, logic [9:0] b2,
                              logic [9:0] b3, logic [9:0] b4, logic [9:0] b5, logic [9:0] tgt,
                              logic ef, int emin, int emask);
    vec_t v;
    v = '0;
    v.nl = 4'(nl); v.nb = 4'(nb);
    v.btn[0] = b0; v.btn[1] = b1; v.btn[2] = b2; v.btn[3] = b3; v.btn[4] = b4; v.btn[5] = b5;
    v.tgt = tgt; v.ef = ef; v.emin = 4'(emin); v.emask = 13'(emask);
    return v;
  endfunction

  function automatic int exp_lat(vec_t v);
    int n;
    int lat;
    n = (v.nb > 4'd13) ? 13 : int'(v.nb);
    lat = (1 << n) + 1;
`ifdef DAY10_EARLY_EXIT_EN
    if (v.ef && v.emin <= 4'd1) lat = int'(v.emask) + 2;
`endif
    return lat;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a machine for exactly one accept edge, then scramble the bus
  task automatic start(vec_t v, string name);
    mif.num_lights = v.nl;
    mif.num_buttons = v.nb;
    for (int i = 0; i < 13; i++) mif.buttons[i] = v.btn[i];
    mif.target_lights_arrangement = v.tgt;
    in_valid = 1'b1;
    check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    mif.num_lights = 4'($urandom);
    mif.num_buttons = 4'($urandom_range(0, 13));
    for (int i = 0; i < 13; i++) mif.buttons[i] = 10'($urandom);
    mif.target_lights_arrangement = 10'($urandom);
  endtask

  task automatic wait_result(vec_t v, string name);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20000) begin
      check({name, " in_ready low while busy"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat(v)));
    check({name, " found"}, 32'(found), 32'(v.ef));
    check({name, " min_presses"}, 32'(min_presses), 32'(v.emin));
    check({name, " best_mask"}, 32'(best_mask), 32'(v.emask));
  endtask

  task automatic handshake(string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid dropped"}, 32'(out_valid), 32'd0);
    check({name, " in_ready restored"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    vecs[0]  = mk(4, 6, 10'b1000, 10'b1010, 10'b0100, 10'b1100, 10'b0101, 10'b0011, 10'b0110, 1, 2, 13'b001010);
    vecs[1]  = mk(4, 5, 10'h1, 10'h2, 10'h4, 10'h8, 10'hF, 10'h0, 10'h0, 1, 0, 0);
    vecs[2]  = mk(4, 1, 10'b0001, 0, 0, 0, 0, 0, 10'b0010, 0, 0, 0);
    vecs[3]  = mk(2, 2, 10'b1101, 10'b0110, 0, 0, 0, 0, 10'b0001, 1, 1, 13'b01);
    vecs[4]  = mk(2, 2, 10'b1101, 10'b0110, 0, 0, 0, 0, 10'b1110, 1, 1, 13'b10);
    vecs[5]  = mk(4, 2, 10'h1, 10'h2, 10'h4, 0, 0, 0, 10'h4, 0, 0, 0);
    vecs[6]  = mk(4, 0, 10'hF, 0, 0, 0, 0, 0, 10'h0, 1, 0, 0);
    vecs[7]  = mk(4, 0, 10'h1, 0, 0, 0, 0, 0, 10'h1, 0, 0, 0);
    vecs[8]  = mk(4, 3, 10'b0011, 10'b0101, 10'b0110, 0, 0, 0, 10'b0011, 1, 1, 13'b001);
    vecs[9]  = mk(4, 4, 10'h1, 10'h2, 10'h4, 10'h8, 0, 0, 10'h7, 1, 3, 13'b0111);
    vecs[10] = mk(15, 2, 10'h200, 10'h001, 0, 0, 0, 0, 10'h201, 1, 2, 13'b11);
    vecs[11] = mk(4, 3, 10'h1, 10'h1, 10'h1, 0, 0, 0, 10'h1, 1, 1, 13'b001);
    vecs[12] = mk(0, 2, 10'h1, 10'h2, 0, 0, 0, 0, 10'hF, 1, 0, 0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mif.num_lights = '0; mif.num_buttons = '0;
    for (int i = 0; i < 13; i++) mif.buttons[i] = '0;
    mif.target_lights_arrangement = '0;
    repeat (3) tick();
    check("reset state", 32'({in_ready, out_valid, found, min_presses, best_mask}), 32'({1'b1, 1'b0, 1'b0, 4'd0, 13'd0}));
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < NVEC; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      start(vecs[t], nm);
      wait_result(vecs[t], nm);
      handshake(nm);
    end

    // Backpressure: outputs frozen for 10 cycles, then a second machine
    start(vecs[0], "bp");
    wait_result(vecs[0], "bp");
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("bp hold cycle %0d", c), 32'({out_valid, in_ready, found, min_presses, best_mask}),
            32'({1'b1, 1'b0, vecs[0].ef, vecs[0].emin, vecs[0].emask}));
    end
    handshake("bp");
    start(vecs[3], "bp second");
    wait_result(vecs[3], "bp second");
    handshake("bp second");

    // Reset asserted in cycle T+20 of the worked example
    start(vecs[0], "rst");
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    check("rst mid-search values", 32'({in_ready, out_valid, found, min_presses, best_mask}), 32'({1'b1, 1'b0, 1'b0, 4'd0, 13'd0}));
    rst_n = 1'b1;
    out_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (out_valid || !in_ready) pulses++;
    end
    out_ready = 1'b0;
    check("rst no stray result", 32'(pulses), 32'd0);
    start(vecs[0], "rst reissue");
    wait_result(vecs[0], "rst reissue");
    handshake("rst reissue");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
